// File: rtl/wfg_drive_spi_arb_pkg.sv
// wfg_drive_spi_arb_pkg: shared state type and arbitration helpers for the SPI drive arbiter
package wfg_drive_spi_arb_pkg;
  localparam int MAX_REQ = 8;
  typedef enum logic {IDLE, GRANT} state_t;
  // Scans from the farthest slot back to ptr so the nearest set bit is the last one written.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int n = MAX_REQ);
    logic [MAX_REQ-1:0] g;
    int k;
    g = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % n;
      if (i < n && req[k[2:0]]) g = 8'd1 << k[2:0];
    end
    return g;
  endfunction
  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/wfg_rr_arbiter.sv
// wfg_rr_arbiter: combinational round-robin / fixed-priority winner selection
module wfg_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               fixed,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  import wfg_drive_spi_arb_pkg::*;
  logic [MAX_REQ-1:0] pick;
  always_comb begin
    pick = rr_pick(MAX_REQ'(req), fixed ? 3'd0 : 3'(ptr), NUM_REQ);
    gnt = NUM_REQ'(pick);
    idx = IW'(onehot2idx(pick));
  end
endmodule

// File: rtl/wfg_drive_spi_arbiter.sv
// wfg_drive_spi_arbiter: packet-level arbiter sharing one SPI drive stream sink between requesters
module wfg_drive_spi_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic                               ctrl_en_q_i,
  input  logic [NUM_REQ-1:0]                 cfg_mask_q_i,
  input  logic                               cfg_fixed_prio_q_i,
  input  logic                               cfg_sync_en_q_i,
  input  logic                               wfg_core_sync_i,
  input  logic [NUM_REQ-1:0]                 s_axis_tvalid_i,
  input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_REQ-1:0]                 s_axis_tlast_i,
  output logic [NUM_REQ-1:0]                 s_axis_tready_o,
  output logic                               m_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata_o,
  output logic                               m_axis_tlast_o,
  input  logic                               m_axis_tready_i,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic                               busy_o
);
  import wfg_drive_spi_arb_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_nx;
  logic [NUM_REQ-1:0] req, win, grant;
  logic [IW-1:0] win_idx, gidx, rr_ptr;
  logic start, done;
  assign req = s_axis_tvalid_i & cfg_mask_q_i;
  assign start = ctrl_en_q_i && |req && (!cfg_sync_en_q_i || wfg_core_sync_i);
  assign done = m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o;
  wfg_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .fixed(cfg_fixed_prio_q_i),
    .gnt(win),
    .idx(win_idx)
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        grant <= win;
        gidx <= win_idx;
      end else if (done) begin
        grant <= '0;
        rr_ptr <= gidx == IW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end
    end
  end
  always_comb state_nx = state == IDLE ? (start ? GRANT : IDLE) : (done ? IDLE : GRANT);
  // Stream mux is driven straight from the registered grant so beats pass with zero latency.
  always_comb begin
    busy_o = state == GRANT;
    grant_o = grant;
    m_axis_tvalid_o = busy_o & s_axis_tvalid_i[gidx];
    m_axis_tlast_o = busy_o & s_axis_tlast_i[gidx];
    m_axis_tdata_o = busy_o ? s_axis_tdata_i[gidx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] : '0;
    s_axis_tready_o = busy_o ? NUM_REQ'(m_axis_tready_i) << gidx : '0;
  end
endmodule

// File: tb/tb_wfg_drive_spi_arbiter.sv
// tb_wfg_drive_spi_arbiter: table-driven directed bench for the SPI drive arbiter
module tb_wfg_drive_spi_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, en, fixed, sen, sync, mrdy;
  logic [N-1:0] mask, tv, tl, tready, grant;
  logic [N*W-1:0] tdata;
  logic mvalid, mlast, busy;
  logic [W-1:0] mdata;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  wfg_drive_spi_arbiter #(.NUM_REQ(N), .AXIS_DATA_WIDTH(W)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .ctrl_en_q_i(en),
    .cfg_mask_q_i(mask),
    .cfg_fixed_prio_q_i(fixed),
    .cfg_sync_en_q_i(sen),
    .wfg_core_sync_i(sync),
    .s_axis_tvalid_i(tv),
    .s_axis_tdata_i(tdata),
    .s_axis_tlast_i(tl),
    .s_axis_tready_o(tready),
    .m_axis_tvalid_o(mvalid),
    .m_axis_tdata_o(mdata),
    .m_axis_tlast_o(mlast),
    .m_axis_tready_i(mrdy),
    .grant_o(grant),
    .busy_o(busy)
  );
  typedef struct {
    logic       rst, en;
    logic [3:0] mask;
    logic       fixed, sen, sync;
    logic [3:0] tv, tl;
    logic       mrdy;
    logic [3:0] gnt;
  } vec_t;
  vec_t vecs[$];
  function automatic void add(input logic r, e, input logic [3:0] m, input logic f, s, y,
                              input logic [3:0] v, l, input logic rd, input logic [3:0] g);
    vecs.push_back('{r, e, m, f, s, y, v, l, rd, g});
  endfunction
  function automatic logic [31:0] dval(input int k, input int r);
    return 32'hA5A50000 | (32'(k) << 12) | 32'(r);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    vec_t v;
    logic [31:0] ed;
    int b;
    rst = 1'b1; en = 1'b0; mask = '0; fixed = 1'b0; sen = 1'b0; sync = 1'b0;
    tv = '0; tl = '0; mrdy = 1'b0; tdata = '0;
    // round-robin, 2-beat packets, all requesters valid
    add(0,1,4'hF,0,0,0,4'h0,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h1);
    add(0,1,4'hF,0,0,0,4'hF,4'hF,1,4'h1);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h2);
    add(0,1,4'hF,0,0,0,4'hF,4'hF,1,4'h2);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h4);
    add(0,1,4'hF,0,0,0,4'hF,4'hF,1,4'h4);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h8);
    add(0,1,4'hF,0,0,0,4'hF,4'hF,1,4'h8);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'hF,4'hF,1,4'h1);
    // fixed priority, requesters 1 and 3; mask bit 1 cleared mid-packet
    add(0,1,4'hF,1,0,0,4'hA,4'h0,1,4'h0);
    add(0,1,4'hF,1,0,0,4'hA,4'h0,1,4'h2);
    add(0,1,4'hF,1,0,0,4'hA,4'hA,1,4'h2);
    add(0,1,4'hF,1,0,0,4'hA,4'h0,1,4'h0);
    add(0,1,4'hD,1,0,0,4'hA,4'h0,1,4'h2);
    add(0,1,4'hD,1,0,0,4'hA,4'hA,1,4'h2);
    add(0,1,4'hD,1,0,0,4'hA,4'h0,1,4'h0);
    add(0,1,4'hD,1,0,0,4'hA,4'hA,1,4'h8);
    // backpressure and mid-packet valid drop on requester 2
    add(0,1,4'hF,0,0,0,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'h4,4'h0,1,4'h4);
    add(0,1,4'hF,0,0,0,4'h4,4'h0,0,4'h4);
    add(0,1,4'hF,0,0,0,4'h4,4'h0,1,4'h4);
    add(0,1,4'hF,0,0,0,4'h4,4'h0,0,4'h4);
    add(0,1,4'hF,0,0,0,4'h0,4'h0,1,4'h4);
    add(0,1,4'hF,0,0,0,4'h4,4'h0,1,4'h4);
    add(0,1,4'hF,0,0,0,4'h4,4'h4,0,4'h4);
    add(0,1,4'hF,0,0,0,4'h4,4'h4,1,4'h4);
    add(0,1,4'hF,0,0,0,4'h0,4'h0,1,4'h0);
    // enable falls mid-packet
    add(0,1,4'hF,0,0,0,4'h1,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'h1,4'h0,1,4'h1);
    add(0,0,4'hF,0,0,0,4'h1,4'h0,1,4'h1);
    add(0,0,4'hF,0,0,0,4'h1,4'h0,1,4'h1);
    add(0,0,4'hF,0,0,0,4'h1,4'h1,1,4'h1);
    add(0,0,4'hF,0,0,0,4'h1,4'h0,1,4'h0);
    add(0,0,4'hF,0,0,0,4'h1,4'h0,1,4'h0);
    // sync alignment; a pulse during GRANT is not remembered
    add(0,1,4'hF,0,1,0,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,1,1,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,1,0,4'h4,4'h4,1,4'h4);
    add(0,1,4'hF,0,1,0,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,1,0,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,1,1,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,1,1,4'h4,4'h0,1,4'h4);
    add(0,1,4'hF,0,1,0,4'h4,4'h4,1,4'h4);
    add(0,1,4'hF,0,1,0,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,1,1,4'h4,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'h4,4'h0,1,4'h4);
    // reset mid-packet, then pointer restarts at 0
    add(1,1,4'hF,0,0,0,4'h4,4'h0,1,4'h4);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h0);
    add(0,1,4'hF,0,0,0,4'hF,4'h0,1,4'h1);
    add(0,1,4'hF,0,0,0,4'hF,4'hF,1,4'h1);
    add(0,1,4'hF,0,0,0,4'h0,4'h0,1,4'h0);
    // fully masked requesters are never granted
    add(0,1,4'h0,0,0,0,4'hF,4'h0,1,4'h0);
    add(0,1,4'h0,0,0,0,4'hF,4'h0,1,4'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset grant", 32'(grant), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset mvalid", 32'(mvalid), 0);
    chk("reset mlast", 32'(mlast), 0);
    chk("reset mdata", mdata, 0);
    chk("reset tready", 32'(tready), 0);
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; en = v.en; mask = v.mask; fixed = v.fixed; sen = v.sen; sync = v.sync;
      tv = v.tv; tl = v.tl; mrdy = v.mrdy;
      for (int k = 0; k < N; k++) tdata[k*W +: W] = dval(k, i);
      #1;
      ed = '0;
      for (int k = 0; k < N; k++) if (v.gnt[k]) ed = dval(k, i);
      chk($sformatf("r%0d grant", i), 32'(grant), 32'(v.gnt));
      chk($sformatf("r%0d busy", i), 32'(busy), 32'(|v.gnt));
      chk($sformatf("r%0d mvalid", i), 32'(mvalid), 32'(|(v.gnt & v.tv)));
      chk($sformatf("r%0d mlast", i), 32'(mlast), 32'(|(v.gnt & v.tl)));
      chk($sformatf("r%0d mdata", i), mdata, ed);
      chk($sformatf("r%0d tready", i), 32'(tready), 32'(v.gnt & {4{v.mrdy}}));
      @(negedge clk);
    end
    // sync pulses at cycles 3 and 20, requester 2 valid from cycle 5
    rst = 1'b0; en = 1'b1; mask = 4'hF; fixed = 1'b0; sen = 1'b1; mrdy = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      sync = c == 3 || c == 20;
      tv = c >= 5 ? 4'h4 : 4'h0;
      tl = c == 22 ? 4'h4 : 4'h0;
      #1;
      chk($sformatf("sync c%0d grant", c), 32'(grant), c >= 21 ? 32'h4 : 32'h0);
      chk($sformatf("sync c%0d mvalid", c), 32'(mvalid), 32'(c >= 21));
      @(negedge clk);
    end
    sync = 1'b0; tv = '0; tl = '0;
    #1;
    chk("sync bubble busy", 32'(busy), 0);
    // backpressure: ready toggles, requester 1 streams four beats
    @(negedge clk);
    sen = 1'b0;
    b = 0;
    for (int c = 0; c < 20 && b < 4; c++) begin
      mrdy = c % 2 == 0;
      tv = 4'h2;
      tdata[W +: W] = 32'hA5A50001 + 32'(b);
      tl = b == 3 ? 4'h2 : 4'h0;
      #1;
      chk($sformatf("bp c%0d other readies", c), 32'(tready & 4'hD), 0);
      if (mvalid && mrdy) begin
        chk($sformatf("bp beat%0d data", b), mdata, 32'hA5A50001 + 32'(b));
        chk($sformatf("bp beat%0d last", b), 32'(mlast), 32'(b == 3));
        b++;
      end
      @(negedge clk);
    end
    chk("bp beat count", 32'(b), 4);
    tv = '0; tl = '0;
    #1;
    chk("bp bubble busy", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
